// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - iterative shift-and-add unsigned multiplier; SHIFT_ADD_MULT_EARLY_TERM_EN enables early termination
module shift_add_mult #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 valid_data,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [CNT_W-1:0]     cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]     cycles_q, cycles_d;

    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_shr;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 last_iter;

    // State and datapath registers; reset clears everything, even mid-run
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            cycles_q  <= cycles_d;
        end
    end

    // Next-state and datapath: capture in IDLE, one add/shift per CALC edge, hold in DONE
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        cycles_d   = cycles_q;

        acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shr = mplier_q >> 1;
        cnt_inc    = cnt_q + 1'b1;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        // Once the remaining multiplier bits are all zero no further add can occur
        last_iter  = (cnt_inc == CNT_MAX) || (mplier_shr == '0);
`else
        last_iter  = (cnt_inc == CNT_MAX);
`endif

        case (state_q)
            IDLE: begin
                if (valid_data) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_inc;
                if (last_iter) begin
                    // Result registers load on the final edge so they are valid on DONE entry
                    product_d = acc_sum;
                    cycles_d  = cnt_inc;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state and result registers only
    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = product_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - directed self-checking bench for shift_add_mult (WIDTH 8 and 32)
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v8, ack8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic [3:0]  c8;

    logic        v32, ack32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] p32;
    logic [5:0]  c32;

    int errors = 0;
    int checks = 0;
    int n, m;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    localparam int C32_B2  = 2;
    localparam int C8_B0   = 1;
    localparam int C8_B34  = 6;
    localparam int C8_B5   = 3;
    localparam int C8_B9   = 4;
`else
    localparam int C32_B2  = 32;
    localparam int C8_B0   = 8;
    localparam int C8_B34  = 8;
    localparam int C8_B5   = 8;
    localparam int C8_B9   = 8;
`endif

    always #5 clk = ~clk;

    shift_add_mult #(.WIDTH(8)) u8 (
        .Clock(clk), .Reset(rst_n), .valid_data(v8), .a(a8), .b(b8), .ack(ack8),
        .busy(busy8), .done(done8), .product(p8), .cycles(c8)
    );

    shift_add_mult #(.WIDTH(32)) u32 (
        .Clock(clk), .Reset(rst_n), .valid_data(v32), .a(a32), .b(b32), .ack(ack32),
        .busy(busy32), .done(done32), .product(p32), .cycles(c32)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        a8 = a; b8 = b; v8 = 1'b1;
        step();
        v8 = 1'b0;
        check("busy8_after_capture", busy8, 1'b1);
    endtask

    task automatic wait8(output int cnt);
        cnt = 0;
        while (!done8 && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait32(output int cnt);
        cnt = 0;
        while (!done32 && cnt < 200) begin
            step();
            cnt++;
        end
    endtask

    task automatic ack_8();
        ack8 = 1'b1;
        step();
        ack8 = 1'b0;
        check("done8_after_ack", done8, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 0; ack8 = 0; a8 = 0; b8 = 0;
        v32 = 0; ack32 = 0; a32 = 0; b32 = 0;
        step();
        step();
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_p8", p8, 16'h0);
        check("rst_c8", c8, 4'h0);
        check("rst_busy32", busy32, 1'b0);
        check("rst_done32", done32, 1'b0);
        check("rst_p32", p32, 64'h0);
        check("rst_c32", c32, 6'h0);
        rst_n = 1'b1;

        // Idle with no request and a stray ack: nothing happens
        ack8 = 1'b1;
        step();
        step();
        check("idle_busy8", busy8, 1'b0);
        check("idle_done8", done8, 1'b0);
        ack8 = 1'b0;

        // 0xFF * 0xFF, ack held low, operands and valid wiggled while DONE
        start8(8'hFF, 8'hFF);
        wait8(n);
        check("ff_latency", n, 8);
        check("ff_product", p8, 16'hFE01);
        check("ff_cycles", c8, 4'd8);
        check("ff_busy_low", busy8, 1'b0);
        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); v8 = 1'b1;
            step();
            check("ff_hold_done", done8, 1'b1);
            check("ff_hold_product", p8, 16'hFE01);
            check("ff_hold_cycles", c8, 4'd8);
        end
        v8 = 1'b0;
        ack_8();
        check("ff_idle_busy", busy8, 1'b0);
        step();
        check("ff_idle_product", p8, 16'hFE01);
        check("ff_idle_cycles", c8, 4'd8);

        // WIDTH=32: 0xFFFFFFFF * 2
        a32 = 32'hFFFF_FFFF; b32 = 32'h2; v32 = 1'b1;
        step();
        v32 = 1'b0;
        check("w32_busy", busy32, 1'b1);
        wait32(n);
        check("w32_latency", n, C32_B2);
        check("w32_product", p32, 64'h1_FFFF_FFFE);
        check("w32_cycles", c32, C32_B2);
        ack32 = 1'b1;
        step();
        ack32 = 1'b0;
        check("w32_done_low", done32, 1'b0);

        // b = 0
        start8(8'hA5, 8'h00);
        wait8(n);
        check("b0_latency", n, C8_B0);
        check("b0_product", p8, 16'h0);
        check("b0_cycles", c8, C8_B0);
        ack_8();

        // ack during CALC is ignored: 0x12 * 0x34
        start8(8'h12, 8'h34);
        ack8 = 1'b1;
        step();
        step();
        step();
        ack8 = 1'b0;
        check("ackcalc_busy", busy8, 1'b1);
        wait8(m);
        n = 3 + m;
        check("ackcalc_latency", n, C8_B34);
        check("ackcalc_product", p8, 16'h03A8);
        check("ackcalc_cycles", c8, C8_B34);
        ack_8();

        // Asynchronous reset at iteration 4
        start8(8'hFF, 8'hFF);
        step(); step(); step(); step();
        check("rstmid_busy_before", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy8, 1'b0);
        check("rstmid_done", done8, 1'b0);
        check("rstmid_product", p8, 16'h0);
        check("rstmid_cycles", c8, 4'h0);
        step();
        rst_n = 1'b1;
        start8(8'd3, 8'd5);
        wait8(n);
        check("postrst_latency", n, C8_B5);
        check("postrst_product", p8, 16'd15);
        check("postrst_cycles", c8, C8_B5);

        // valid and ack together in DONE: ack first, then capture
        a8 = 8'd7; b8 = 8'd9; v8 = 1'b1; ack8 = 1'b1;
        step();
        ack8 = 1'b0;
        check("va_done_low", done8, 1'b0);
        check("va_busy_low", busy8, 1'b0);
        check("va_product_held", p8, 16'd15);
        step();
        v8 = 1'b0;
        check("va_captured", busy8, 1'b1);
        check("va_done_still_low", done8, 1'b0);
        wait8(n);
        check("va_latency", n, C8_B9);
        check("va_product", p8, 16'd63);
        check("va_cycles", c8, C8_B9);
        ack_8();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
